// File: rtl/bp_me_pkg.sv
// ============================================================================
// Module : bp_me_pkg
// Brief  : Shared DMA responder types: FSM state enum, DMA packet layout and a
//          width helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_me_pkg;

  localparam int c_dma_caddr_width = 28;

  typedef enum logic [1:0] {
    e_dma_idle    = 2'd0,
    e_dma_rd_wait = 2'd1,
    e_dma_rd_send = 2'd2,
    e_dma_wr_recv = 2'd3
  } bp_dma_resp_state_e;

  // Canonical bsg_cache DMA packet: direction bit above the byte address.
  typedef struct packed {
    logic                         write_not_read;
    logic [c_dma_caddr_width-1:0] addr;
  } bp_dma_pkt_s;

  function automatic int bp_lg_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_cache_dma_responder_mem.sv
// ============================================================================
// Module : bp_cache_dma_responder_mem
// Brief  : Fill-width register array, one synchronous write port and one
//          combinational read port. Contents are not reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_cache_dma_responder_mem
  import bp_me_pkg::*;
#(
  parameter int width_p      = 64,
  parameter int els_p        = 128,
  parameter int addr_width_p = 7
) (
  input  logic                    clk_i,
  input  logic                    w_v_i,
  input  logic [addr_width_p-1:0] w_addr_i,
  input  logic [width_p-1:0]      w_data_i,
  input  logic [addr_width_p-1:0] r_addr_i,
  output logic [width_p-1:0]      r_data_o
);

  logic [width_p-1:0] r_mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) r_mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = r_mem[r_addr_i];

endmodule

`default_nettype wire

// File: rtl/bp_cache_dma_responder.sv
// ============================================================================
// Module : bp_cache_dma_responder
// Brief  : Memory-side bsg_cache DMA responder backed by a register array.
//          Optional macro BP_DMA_RESP_RANGE_CHECK_EN enables a sticky
//          out-of-range flag on error_o.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_cache_dma_responder
  import bp_me_pkg::*;
#(
  parameter int caddr_width_p  = 28,
  parameter int fill_width_p   = 64,
  parameter int block_width_p  = 512,
  parameter int mem_els_p      = 16,
  parameter int read_latency_p = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [caddr_width_p:0]   dma_pkt_i,
  input  logic                     dma_pkt_v_i,
  output logic                     dma_pkt_yumi_o,
  output logic [fill_width_p-1:0]  dma_data_o,
  output logic                     dma_data_v_o,
  input  logic                     dma_data_ready_and_i,
  input  logic [fill_width_p-1:0]  dma_data_i,
  input  logic                     dma_data_v_i,
  output logic                     dma_data_yumi_o,
  output logic                     error_o
);

  localparam int c_beats      = block_width_p / fill_width_p;
  localparam int c_offset_w   = $clog2(block_width_p / 8);
  localparam int c_idx_w      = bp_lg_min1(mem_els_p);
  localparam int c_beat_w     = bp_lg_min1(c_beats);
  localparam int c_lat_w      = bp_lg_min1(read_latency_p + 1);
  localparam int c_mem_els    = mem_els_p * c_beats;
  localparam int c_mem_addr_w = bp_lg_min1(c_mem_els);
  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);
  localparam logic [c_lat_w-1:0]  c_lat_load  =
      c_lat_w'((read_latency_p > 0) ? read_latency_p - 1 : 0);

  typedef struct packed {
    logic                     write_not_read;
    logic [caddr_width_p-1:0] addr;
  } dma_pkt_s;

  dma_pkt_s                 w_pkt;
  logic [c_idx_w-1:0]       w_pkt_blk_idx;
  logic                     w_unused_addr;
  bp_dma_resp_state_e       r_state, w_state_nxt;
  logic [c_idx_w-1:0]       r_blk_idx;
  logic [c_beat_w-1:0]      r_beat;
  logic [c_lat_w-1:0]       r_lat;
  logic                     w_pkt_yumi, w_data_v, w_data_yumi, w_beat_adv;
  logic                     w_mem_w_v;
  logic [c_mem_addr_w-1:0]  w_mem_addr;
  logic [fill_width_p-1:0]  w_mem_rdata;

  assign w_pkt         = dma_pkt_i;
  assign w_unused_addr = ^w_pkt.addr;

  generate
    if (mem_els_p > 1) begin : g_blk_idx
      assign w_pkt_blk_idx = w_pkt.addr[c_offset_w +: c_idx_w];
    end else begin : g_blk_idx_zero
      assign w_pkt_blk_idx = '0;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_pkt_yumi  = 1'b0;
    w_data_v    = 1'b0;
    w_data_yumi = 1'b0;
    case (r_state)
      e_dma_idle: begin
        // Gate on reset so the combinational yumi is 0 while held in reset.
        w_pkt_yumi = dma_pkt_v_i & reset_n_i;
        if (w_pkt_yumi) begin
          if (w_pkt.write_not_read)     w_state_nxt = e_dma_wr_recv;
          else if (read_latency_p == 0) w_state_nxt = e_dma_rd_send;
          else                          w_state_nxt = e_dma_rd_wait;
        end
      end
      e_dma_rd_wait: begin
        if (r_lat == '0) w_state_nxt = e_dma_rd_send;
      end
      e_dma_rd_send: begin
        w_data_v = 1'b1;
        if (dma_data_ready_and_i && (r_beat == c_last_beat)) w_state_nxt = e_dma_idle;
      end
      e_dma_wr_recv: begin
        w_data_yumi = dma_data_v_i;
        if (dma_data_v_i && (r_beat == c_last_beat)) w_state_nxt = e_dma_idle;
      end
      default: w_state_nxt = e_dma_idle;
    endcase
  end

  assign w_beat_adv = (w_data_v & dma_data_ready_and_i) | w_data_yumi;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= e_dma_idle;
      r_blk_idx <= '0;
      r_beat    <= '0;
      r_lat     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pkt_yumi) begin
        r_blk_idx <= w_pkt_blk_idx;
        r_beat    <= '0;
        r_lat     <= c_lat_load;
      end else begin
        if (r_state == e_dma_rd_wait) r_lat <= r_lat - c_lat_w'(1);
        if (w_beat_adv) r_beat <= (r_beat == c_last_beat) ? '0 : r_beat + c_beat_w'(1);
      end
    end
  end

  assign w_mem_addr = c_mem_addr_w'(r_blk_idx) * c_mem_addr_w'(c_beats) + c_mem_addr_w'(r_beat);

  bp_cache_dma_responder_mem #(
    .width_p      (fill_width_p),
    .els_p        (c_mem_els),
    .addr_width_p (c_mem_addr_w)
  ) u_mem (
    .clk_i    (clk_i),
    .w_v_i    (w_mem_w_v),
    .w_addr_i (w_mem_addr),
    .w_data_i (dma_data_i),
    .r_addr_i (w_mem_addr),
    .r_data_o (w_mem_rdata)
  );

`ifdef BP_DMA_RESP_RANGE_CHECK_EN
  localparam int c_hi_lsb = c_offset_w + $clog2(mem_els_p);
  logic w_pkt_oor, r_oor, r_error;

  generate
    if (c_hi_lsb < caddr_width_p) begin : g_oor
      assign w_pkt_oor = |w_pkt.addr[caddr_width_p-1:c_hi_lsb];
    end else begin : g_oor_none
      assign w_pkt_oor = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_oor   <= 1'b0;
      r_error <= 1'b0;
    end else if (w_pkt_yumi) begin
      r_oor   <= w_pkt_oor;
      r_error <= r_error | w_pkt_oor;
    end
  end

  assign error_o    = r_error;
  assign w_mem_w_v  = w_data_yumi & ~r_oor;
  assign dma_data_o = (w_data_v & ~r_oor) ? w_mem_rdata : '0;
`else
  assign error_o    = 1'b0;
  assign w_mem_w_v  = w_data_yumi;
  assign dma_data_o = w_data_v ? w_mem_rdata : '0;
`endif

  assign dma_pkt_yumi_o  = w_pkt_yumi;
  assign dma_data_v_o    = w_data_v;
  assign dma_data_yumi_o = w_data_yumi;

endmodule

`default_nettype wire

// File: tb/tb_bp_cache_dma_responder.sv
// ============================================================================
// Module : tb_bp_cache_dma_responder
// Brief  : Directed self-checking bench for bp_cache_dma_responder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_cache_dma_responder;

  localparam int CW = 28;
  localparam int FW = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CW:0]   dma_pkt = '0;
  logic          dma_pkt_v = 1'b0;
  logic          dma_pkt_yumi;
  logic [FW-1:0] dma_data_out;
  logic          dma_data_v_out;
  logic          dma_ready = 1'b0;
  logic [FW-1:0] dma_data_in = '0;
  logic          dma_data_v_in = 1'b0;
  logic          dma_data_yumi;
  logic          error;

  int n_pass  = 0;
  int n_total = 0;

  logic [FW-1:0] blk0  [8];
  logic [FW-1:0] blk1  [8];
  logic [FW-1:0] blk15 [8];
  logic [FW-1:0] zeros [8];

  always #5 clk = ~clk;

  bp_cache_dma_responder dut (
    .clk_i                (clk),
    .reset_n_i            (reset_n),
    .dma_pkt_i            (dma_pkt),
    .dma_pkt_v_i          (dma_pkt_v),
    .dma_pkt_yumi_o       (dma_pkt_yumi),
    .dma_data_o           (dma_data_out),
    .dma_data_v_o         (dma_data_v_out),
    .dma_data_ready_and_i (dma_ready),
    .dma_data_i           (dma_data_in),
    .dma_data_v_i         (dma_data_v_in),
    .dma_data_yumi_o      (dma_data_yumi),
    .error_o              (error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present a packet, confirm it is consumed, and leave just after acceptance.
  task automatic send_pkt(input logic wr, input logic [CW-1:0] addr);
    dma_pkt_v = 1'b1;
    dma_pkt   = {wr, addr};
    #1;
    check("pkt_yumi", {63'd0, dma_pkt_yumi}, 64'd1);
    step;
    dma_pkt_v = 1'b0;
    dma_pkt   = '0;
  endtask

  task automatic wr_data(input logic [FW-1:0] d [8], input bit gap);
    for (int k = 0; k < 8; k++) begin
      if (gap) begin
        dma_data_v_in = 1'b0;
        #1;
        check("wr_gap_yumi", {63'd0, dma_data_yumi}, 64'd0);
        step;
      end
      dma_data_v_in = 1'b1;
      dma_data_in   = d[k];
      #1;
      check("wr_yumi", {63'd0, dma_data_yumi}, 64'd1);
      step;
    end
    dma_data_v_in = 1'b0;
  endtask

  // Wait out the read latency then collect 8 beats; bp toggles ready 1,0,0,1.
  // With blk set, a pending packet must stay unconsumed until the block ends.
  task automatic rd_data(input logic [FW-1:0] exp [8], input bit bp, input bit blk);
    int wait_c = 0;
    int k = 0;
    int p = 0;
    int guard = 0;
    logic [3:0] pat = 4'b1001;
    #1;
    while (!dma_data_v_out && wait_c < 20) begin
      if (blk) check("blk_wait_yumi", {63'd0, dma_pkt_yumi}, 64'd0);
      step;
      #1;
      wait_c++;
    end
    check("rd_latency", 64'(wait_c), 64'd2);
    if (wait_c >= 20) return;
    while (k < 8 && guard < 40) begin
      dma_ready = bp ? pat[p % 4] : 1'b1;
      #1;
      check("rd_v", {63'd0, dma_data_v_out}, 64'd1);
      check("rd_data", dma_data_out, exp[k]);
      if (blk) check("blk_send_yumi", {63'd0, dma_pkt_yumi}, 64'd0);
      step;
      #1;
      if (dma_ready) k++;
      p++;
      guard++;
    end
    dma_ready = 1'b0;
    check("rd_beats", 64'(k), 64'd8);
    check("rd_done_v", {63'd0, dma_data_v_out}, 64'd0);
    if (blk) check("blk_accept", {63'd0, dma_pkt_yumi}, 64'd1);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      blk1[k]  = 64'(k + 1);
      blk15[k] = 64'hF00D_0000_0000_0000 | 64'(k * 16 + 3);
      blk0[k]  = 64'hA0 + 64'(k);
      zeros[k] = '0;
    end

    // Outputs must stay low in reset even with every input asserted.
    dma_pkt_v     = 1'b1;
    dma_pkt       = {1'b0, 28'h40};
    dma_data_v_in = 1'b1;
    dma_ready     = 1'b1;
    #12;
    check("rst_pkt_yumi", {63'd0, dma_pkt_yumi}, 64'd0);
    check("rst_data_v", {63'd0, dma_data_v_out}, 64'd0);
    check("rst_data_yumi", {63'd0, dma_data_yumi}, 64'd0);
    check("rst_data", dma_data_out, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    dma_pkt_v     = 1'b0;
    dma_pkt       = '0;
    dma_data_v_in = 1'b0;
    dma_ready     = 1'b0;
    step;
    reset_n = 1'b1;
    step;

    // Write block 1 then read it back with full-rate ready.
    send_pkt(1'b1, 28'h40);
    wr_data(blk1, 1'b0);
    send_pkt(1'b0, 28'h40);
    rd_data(blk1, 1'b0, 1'b0);

    // Same read under backpressure.
    send_pkt(1'b0, 28'h40);
    rd_data(blk1, 1'b1, 1'b0);

    // Gapped write to the top block, then readback.
    send_pkt(1'b1, 28'h3C0);
    wr_data(blk15, 1'b1);
    send_pkt(1'b0, 28'h3C0);
    rd_data(blk15, 1'b0, 1'b0);

    // Second packet held off until the first read completes.
    send_pkt(1'b0, 28'h40);
    dma_pkt_v = 1'b1;
    dma_pkt   = {1'b0, 28'h3C0};
    rd_data(blk1, 1'b0, 1'b1);
    step;
    dma_pkt_v = 1'b0;
    dma_pkt   = '0;
    rd_data(blk15, 1'b0, 1'b0);

    // Reset during the 4th beat of a read.
    send_pkt(1'b0, 28'h40);
    step;
    step;
    dma_ready = 1'b1;
    step;
    step;
    step;
    #1;
    check("mid_beat3_v", {63'd0, dma_data_v_out}, 64'd1);
    check("mid_beat3_data", dma_data_out, blk1[3]);
    reset_n       = 1'b0;
    dma_pkt_v     = 1'b1;
    dma_pkt       = {1'b0, 28'h40};
    dma_data_v_in = 1'b1;
    #1;
    check("mid_rst_v", {63'd0, dma_data_v_out}, 64'd0);
    check("mid_rst_data", dma_data_out, 64'd0);
    check("mid_rst_pkt_yumi", {63'd0, dma_pkt_yumi}, 64'd0);
    check("mid_rst_data_yumi", {63'd0, dma_data_yumi}, 64'd0);
    step;
    step;
    dma_pkt_v     = 1'b0;
    dma_pkt       = '0;
    dma_data_v_in = 1'b0;
    dma_ready     = 1'b0;
    reset_n       = 1'b1;
    step;
    #1;
    check("post_rst_v", {63'd0, dma_data_v_out}, 64'd0);
    step;
    send_pkt(1'b0, 28'h40);
    rd_data(blk1, 1'b0, 1'b0);

    // Address one block past capacity.
    send_pkt(1'b1, 28'h0);
    wr_data(blk0, 1'b0);
    send_pkt(1'b0, 28'h400);
`ifdef BP_DMA_RESP_RANGE_CHECK_EN
    check("range_error", {63'd0, error}, 64'd1);
    rd_data(zeros, 1'b0, 1'b0);
    check("range_error_sticky", {63'd0, error}, 64'd1);
`else
    check("range_error", {63'd0, error}, 64'd0);
    rd_data(blk0, 1'b0, 1'b0);
    check("range_error_sticky", {63'd0, error}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/bp_cache_dma_responder.md
Name: bp_cache_dma_responder

Overview:
- Memory-side responder for the bsg_cache DMA interface driven by the unicore L2.
- Accepts DMA packets, streams fill beats back for reads, and absorbs writeback beats for writes.
- Backed by an internal fill-width register array. Used as the DRAM stand-in in unicore testbenches and small FPGA builds.

Parameters:
- caddr_width_p, 28: cache address width; DMA packet width is caddr_width_p+1.
- fill_width_p, 64: width of one DMA data beat.
- block_width_p, 512: cache block width. block_width_p/fill_width_p = beats per block; must be an integer ≥1.
- mem_els_p, 16: backing-store capacity in blocks (power of 2).
- read_latency_p, 2: idle cycles between read-packet acceptance and the first read beat (≥0).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- dma_pkt_i  in  caddr_width_p+1  packet: MSB = write_not_read, low caddr_width_p bits = byte address
- dma_pkt_v_i  in  1  packet valid
- dma_pkt_yumi_o  out  1  packet consumed
- dma_data_o  out  fill_width_p  read beat to cache
- dma_data_v_o  out  1  read beat valid
- dma_data_ready_and_i  in  1  cache accepts read beat
- dma_data_i  in  fill_width_p  writeback beat from cache
- dma_data_v_i  in  1  writeback beat valid
- dma_data_yumi_o  out  1  writeback beat consumed
- error_o  out  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. While reset_n_i=0, all outputs are 0, FSM is IDLE, and all counters are 0. The memory array is not reset.
- Reset mid-transfer: the transfer is abandoned. No further beats are produced or consumed after deassertion.
- Address mapping: block index = addr[lg(block_bytes) +: lg(mem_els_p)]. Low block-offset bits are ignored, so packets are treated as block-aligned. Beat k of the block maps to array entry block_index*beats + k.
- FSM states: IDLE, RD_WAIT, RD_SEND, WR_RECV.
- IDLE:
  - dma_pkt_yumi_o = dma_pkt_v_i (combinational). The packet is accepted in cycle T, and the address and direction are latched.
  - Write packet -> WR_RECV.
  - Read packet with read_latency_p=0 -> RD_SEND. Otherwise -> RD_WAIT with the latency counter loaded to read_latency_p-1.
- RD_WAIT: counter decrements each cycle; at 0 -> RD_SEND. The first beat is therefore valid at cycle T+1+read_latency_p.
- RD_SEND:
  - dma_data_v_o=1 and dma_data_o = array[base+beat] (combinational read).
  - Beat counter advances on v_o & ready_and_i. A stalled beat holds data stable.
  - Handshake on the last beat -> IDLE.
- WR_RECV:
  - dma_data_yumi_o = dma_data_v_i.
  - Each yumi writes dma_data_i to array[base+beat] at the clock edge and advances the beat counter.
  - Yumi on the last beat -> IDLE.
- One transfer at a time: no packet is accepted outside IDLE. The earliest next-packet acceptance is the cycle after the last beat.
- Outside their states, dma_data_v_o=0 and dma_data_yumi_o=0. dma_data_o is don't-care when not valid.
- The beat counter is lg(beats) bits wide. It wraps to 0 on the last beat. The beats=1 case degenerates to a single handshake.

Optional Feature:
- Macro: BP_DMA_RESP_RANGE_CHECK_EN.
- Defined:
  - Any address bit at or above lg(block_bytes)+lg(mem_els_p) that is set marks the transfer out-of-range, and error_o rises the cycle after acceptance. It stays high until reset.
  - Out-of-range reads return all-zero beats with normal timing.
  - Out-of-range writes consume all beats but do not modify the array.
- Undefined: upper address bits are ignored (addresses alias modulo capacity) and error_o is tied 0.

Decomposition:
- Shared package (bp_me_pkg): state enum bp_dma_resp_state_e, and a packet struct {write_not_read, addr} matching the bsg_cache DMA packet layout.
- Local constants: beats per block and the widths of the block-index and beat counters.
- One natural sub-module, bp_cache_dma_responder_mem: fill-width register array with one write port and one combinational read port.

Test Plan:
- Read latency: write pkt addr 0x40, then 8 beats 0x1..0x8, then read pkt addr 0x40. First data_v_o exactly 3 cycles after read acceptance; beats 0x1..0x8 in order.
- Read backpressure: same read with dma_data_ready_and_i toggling 1,0,0,1 -> beats held stable while stalled; no loss or duplication; FSM back in IDLE after the 8th handshake.
- Write gaps: write pkt addr 0x3C0 (block 15) with dma_data_v_i gapped every other cycle -> yumi only when valid; readback from 0x3C0 returns the written beats.
- Packet blocking: second pkt presented during RD_SEND -> dma_pkt_yumi_o=0 until the cycle after the last beat, then accepted.
- Mid-transfer reset: assert reset_n_i low during beat 4 of a read -> all outputs 0 immediately; after release, a new read returns the full block from beat 0.
- Range check (macro on): read pkt addr 0x400 -> error_o=1 next cycle, 8 zero beats returned. Macro off: same access aliases to block 0 and error_o stays 0.
